jogador_automatico: RTL and testbench

Hardware auto-player for jogo_desafio_memoria: the button-pressing end of the game's leds/botoes interface. Watches the game's leds output, records each displayed colour into a 16-entry sequence store, then replays the stored sequence on botoes with programmable press/release timing. It sits beside the game core on the board top-level, muxed onto botoes, for unattended demos and hardware self-test.

---
 rtl/jogador_pkg.sv | 46 ++++
 rtl/jogador_automatico_memoria.sv | 36 +++
 rtl/jogador_automatico.sv | 236 +++++++++++++++++++++++
 tb/tb_jogador_automatico.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jogador_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jogador_pkg
// Purpose  : Shared constants for the jogador_automatico auto-player: state
//            codes, LED one-hot colours and default timing values.
//            Optional feature macro: JOGADA_EXTRA_EN (see jogador_automatico).
// Revision : 1.0 - initial release
// ============================================================================
package jogador_pkg;

    // State codes, also exported on db_estado
    localparam logic [3:0] c_ST_OCIOSO     = 4'd0;
    localparam logic [3:0] c_ST_ESPERA_LED = 4'd1;
    localparam logic [3:0] c_ST_CAPTURA    = 4'd2;
    localparam logic [3:0] c_ST_PRESSIONA  = 4'd3;
    localparam logic [3:0] c_ST_SOLTA      = 4'd4;
    localparam logic [3:0] c_ST_EXTRA      = 4'd5;
    localparam logic [3:0] c_ST_FIM        = 4'd15;

    // One-hot colour codes on leds / botoes
    localparam logic [3:0] c_LED_COR0 = 4'b0001;
    localparam logic [3:0] c_LED_COR1 = 4'b0010;
    localparam logic [3:0] c_LED_COR2 = 4'b0100;
    localparam logic [3:0] c_LED_COR3 = 4'b1000;

    // Default timing / depth values
    localparam int c_IDLE_CYCLES_DEF  = 300;
    localparam int c_PRESS_CYCLES_DEF = 100;
    localparam int c_GAP_CYCLES_DEF   = 100;
    localparam int c_MAX_JOGADAS_DEF  = 16;

    // Maps a 2-bit colour position to its one-hot LED code
    function automatic logic [3:0] led_da_posicao(input logic [1:0] pos);
        logic [3:0] cor;
        case (pos)
            2'd0:    cor = c_LED_COR0;
            2'd1:    cor = c_LED_COR1;
            2'd2:    cor = c_LED_COR2;
            default: cor = c_LED_COR3;
        endcase
        return cor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jogador_automatico_memoria.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jogador_memoria
// Purpose  : MAX_JOGADAS x 4 sequence store, one synchronous write port and
//            one asynchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
module jogador_memoria #(
    parameter int MAX_JOGADAS = 16,
    parameter int IDX_W       = $clog2(MAX_JOGADAS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [3:0]       wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [3:0]       rdata_o
);

    logic [3:0] mem_q [MAX_JOGADAS];

    // Store the raw LED value captured at a pulse start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_JOGADAS; i++) mem_q[i] <= 4'd0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/jogador_automatico.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jogador_automatico
// Purpose  : Auto-player for jogo_desafio_memoria. Records the colours shown
//            on leds into a sequence store, then replays them on botoes with
//            PRESS_CYCLES / GAP_CYCLES timing once leds stay quiet.
//            Optional macro JOGADA_EXTRA_EN: append one rotating extra jogada
//            after each replay (challenge mode).
// Revision : 1.0 - initial release
// ============================================================================
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int IDLE_CYCLES  = c_IDLE_CYCLES_DEF,
    parameter int PRESS_CYCLES = c_PRESS_CYCLES_DEF,
    parameter int GAP_CYCLES   = c_GAP_CYCLES_DEF,
    parameter int MAX_JOGADAS  = c_MAX_JOGADAS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic [3:0] botoes,
    output logic       fim,
    output logic       overflow,
    output logic [3:0] db_estado,
    output logic [4:0] db_contagem
);

    localparam int IDX_W = $clog2(MAX_JOGADAS);
    localparam int CNT_W = IDX_W + 1;
    localparam int TMAX  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int IDL_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(MAX_JOGADAS);
    localparam logic [IDL_W-1:0] c_IDLE_LAST = IDL_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_PRESS_END = TMR_W'(PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_GAP_END   = TMR_W'(GAP_CYCLES - 1);

    logic [3:0]       state_q,    state_d;
    logic [3:0]       leds_q;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [IDL_W-1:0] idle_q,     idle_d;
    logic [TMR_W-1:0] tmr_q,      tmr_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       botoes_q,   botoes_d;
    logic             mem_we;
    logic [3:0]       mem_rdata;
    logic             pulso;
`ifdef JOGADA_EXTRA_EN
    logic [1:0]       ptr_q,      ptr_d;
    logic             fase_gap_q, fase_gap_d;
`endif

    // A new colour starts only on a 0 -> non-zero edge of leds
    assign pulso = (leds_q == 4'd0) && (leds != 4'd0);

    jogador_memoria #(
        .MAX_JOGADAS (MAX_JOGADAS),
        .IDX_W       (IDX_W)
    ) u_memoria (
        .clock   (clock),
        .reset   (reset),
        .we_i    (mem_we),
        .waddr_i (count_q[IDX_W-1:0]),
        .wdata_i (leds),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= c_ST_OCIOSO;
            leds_q     <= 4'd0;
            count_q    <= '0;
            idx_q      <= '0;
            idle_q     <= '0;
            tmr_q      <= '0;
            overflow_q <= 1'b0;
            botoes_q   <= 4'd0;
`ifdef JOGADA_EXTRA_EN
            ptr_q      <= 2'd0;
            fase_gap_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            leds_q     <= leds;
            count_q    <= count_d;
            idx_q      <= idx_d;
            idle_q     <= idle_d;
            tmr_q      <= tmr_d;
            overflow_q <= overflow_d;
            botoes_q   <= botoes_d;
`ifdef JOGADA_EXTRA_EN
            ptr_q      <= ptr_d;
            fase_gap_q <= fase_gap_d;
`endif
        end
    end

    // Next state, counters and the registered button drive
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        idle_d     = idle_q;
        tmr_d      = tmr_q;
        overflow_d = overflow_q;
        botoes_d   = 4'd0;
        mem_we     = 1'b0;
`ifdef JOGADA_EXTRA_EN
        ptr_d      = ptr_q;
        fase_gap_d = fase_gap_q;
`endif
        if (!habilita) begin
            // Disable beats win/lose and throws away any stored sequence
            state_d = c_ST_OCIOSO;
            count_d = '0;
            idle_d  = '0;
            tmr_d   = '0;
        end else if ((ganhou || perdeu) && (state_q != c_ST_OCIOSO)) begin
            state_d = c_ST_FIM;
        end else begin
            case (state_q)
                c_ST_OCIOSO: begin
                    state_d    = c_ST_ESPERA_LED;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    idle_d     = '0;
                end
                c_ST_ESPERA_LED: begin
                    if (leds != 4'd0) begin
                        idle_d = '0;
                        if (pulso) begin
                            if (count_q == c_CNT_MAX) begin
                                overflow_d = 1'b1;
                            end else begin
                                mem_we  = 1'b1;
                                count_d = count_q + CNT_W'(1);
                                state_d = c_ST_CAPTURA;
                            end
                        end
                    end else if ((count_q != '0) && (idle_q == c_IDLE_LAST)) begin
                        state_d = c_ST_PRESSIONA;
                        idx_d   = '0;
                        tmr_d   = '0;
                        idle_d  = '0;
                    end else if (idle_q != c_IDLE_LAST) begin
                        // Saturates so an empty store never wraps into a timeout
                        idle_d = idle_q + IDL_W'(1);
                    end
                end
                c_ST_CAPTURA: begin
                    if (leds == 4'd0) begin
                        state_d = c_ST_ESPERA_LED;
                        idle_d  = '0;
                    end
                end
                c_ST_PRESSIONA: begin
                    botoes_d = mem_rdata;
                    if (tmr_q == c_PRESS_END) begin
                        state_d = c_ST_SOLTA;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                c_ST_SOLTA: begin
                    if (tmr_q == c_GAP_END) begin
                        tmr_d = '0;
                        if ((CNT_W'(idx_q) + CNT_W'(1)) < count_q) begin
                            state_d = c_ST_PRESSIONA;
                            idx_d   = idx_q + IDX_W'(1);
                        end else begin
`ifdef JOGADA_EXTRA_EN
                            state_d    = c_ST_EXTRA;
                            fase_gap_d = 1'b0;
`else
                            state_d = c_ST_ESPERA_LED;
                            count_d = '0;
                            idle_d  = '0;
`endif
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
`ifdef JOGADA_EXTRA_EN
                c_ST_EXTRA: begin
                    if (!fase_gap_q) begin
                        botoes_d = led_da_posicao(ptr_q);
                        if (tmr_q == c_PRESS_END) begin
                            fase_gap_d = 1'b1;
                            tmr_d      = '0;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end else if (tmr_q == c_GAP_END) begin
                        state_d    = c_ST_ESPERA_LED;
                        count_d    = '0;
                        idle_d     = '0;
                        tmr_d      = '0;
                        fase_gap_d = 1'b0;
                        ptr_d      = ptr_q + 2'd1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
`endif
                c_ST_FIM: begin
                    state_d = c_ST_FIM;
                end
                default: begin
                    state_d = c_ST_OCIOSO;
                end
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        botoes      = botoes_q;
        fim         = (state_q == c_ST_FIM);
        overflow    = overflow_q;
        db_estado   = state_q;
        db_contagem = 5'(count_q);
    end

endmodule
`default_nettype wire

// File: tb/tb_jogador_automatico.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jogador_automatico
// Purpose  : Self-checking bench for jogador_automatico. Random LED display
//            phases are replayed and compared against a queue-based model of
//            the expected press/gap sequence and its timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jogador_automatico;

    localparam int IDLE  = 300;
    localparam int PRESS = 100;
    localparam int GAP   = 100;
    localparam int MAX   = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] botoes;
    logic       fim;
    logic       overflow;
    logic [3:0] db_estado;
    logic [4:0] db_contagem;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] seq[$];
    logic       exp_ovf;
    int         exp_ptr;

    jogador_automatico #(
        .IDLE_CYCLES  (IDLE),
        .PRESS_CYCLES (PRESS),
        .GAP_CYCLES   (GAP),
        .MAX_JOGADAS  (MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
        .leds        (leds),
        .ganhou      (ganhou),
        .perdeu      (perdeu),
        .botoes      (botoes),
        .fim         (fim),
        .overflow    (overflow),
        .db_estado   (db_estado),
        .db_contagem (db_contagem)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random display phase of n colours (raw, possibly multi-hot)
    task automatic gen_seq(input int n);
        seq.delete();
        for (int i = 0; i < n; i++) seq.push_back(4'($urandom_range(1, 15)));
    endtask

    // Show seq on leds; fixed widths when w_fix/g_fix non-zero
    task automatic drive_phase(input int w_fix, input int g_fix);
        int w;
        int g;
        for (int i = 0; i < seq.size(); i++) begin
            w = (w_fix != 0) ? w_fix : int'($urandom_range(1, 20));
            g = (g_fix != 0) ? g_fix : int'($urandom_range(1, 40));
            leds = seq[i];
            repeat (w) @(negedge clock);
            leds = 4'd0;
            if (i != seq.size() - 1) repeat (g) @(negedge clock);
        end
        if (seq.size() > MAX) exp_ovf = 1'b1;
    endtask

    // One press or gap: value at current sample, then length of the run
    task automatic seg(input string tag, input logic [3:0] expv, input int expl, input bit last);
        int         len;
        int         limit;
        logic [3:0] v;
        len   = 0;
        limit = last ? expl : 4 * expl + 10;
        check({tag, "_valor"}, 32'(botoes), 32'(expv));
        v = botoes;
        while (botoes == v && len < limit) begin
            len++;
            @(negedge clock);
        end
        check({tag, "_duracao"}, len, expl);
    endtask

    // Bounded wait for botoes to become non-zero (nz=1) or zero (nz=0)
    task automatic wait_botoes(input bit nz);
        int c;
        c = 0;
        while (((botoes != 4'd0) != nz) && c < 2000) begin
            c++;
            @(negedge clock);
        end
        check("espera_botoes", 32'(botoes != 4'd0), 32'(nz));
    endtask

    // Expect full replay of the stored part of seq after the quiet time
    task automatic check_replay();
        int n;
        int exp_cnt;
        int lat;
        int lat_exp;
        n       = seq.size();
        exp_cnt = (n > MAX) ? MAX : n;
        // Quiet count starts after the capture state sees leds drop; an
        // overflowed last pulse is observed directly in the waiting state
        lat_exp = (n > MAX) ? IDLE + 1 : IDLE + 2;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (botoes == 4'd0 && lat < IDLE + 50);
        check("latencia", lat, lat_exp);
        check("contagem", 32'(db_contagem), exp_cnt);
        check("estado_pressiona", 32'(db_estado), 3);
        check("overflow", 32'(overflow), 32'(exp_ovf));
        for (int i = 0; i < exp_cnt; i++) begin
            seg("press", seq[i], PRESS, 1'b0);
`ifdef JOGADA_EXTRA_EN
            seg("gap", 4'd0, GAP, 1'b0);
`else
            seg("gap", 4'd0, GAP, i == exp_cnt - 1);
`endif
        end
`ifdef JOGADA_EXTRA_EN
        seg("extra", 4'(1 << exp_ptr), PRESS, 1'b0);
        seg("gap_extra", 4'd0, GAP, 1'b1);
        exp_ptr = (exp_ptr + 1) % 4;
`endif
        check("estado_apos_replay", 32'(db_estado), 1);
        check("contagem_apos_replay", 32'(db_contagem), 0);
        check("overflow_apos_replay", 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        habilita = 1'b0;
        leds     = 4'd0;
        ganhou   = 1'b0;
        perdeu   = 1'b0;
        exp_ovf  = 1'b0;
        exp_ptr  = 0;
        repeat (3) @(negedge clock);
        check("rst_botoes", 32'(botoes), 0);
        check("rst_estado", 32'(db_estado), 0);
        check("rst_contagem", 32'(db_contagem), 0);
        check("rst_fim", 32'(fim), 0);
        check("rst_overflow", 32'(overflow), 0);

        reset    = 1'b1;
        habilita = 1'b1;
        @(negedge clock);
        check("ocioso_para_espera", 32'(db_estado), 1);

        // Directed three-colour phase
        seq = '{4'b0001, 4'b0010, 4'b0100};
        drive_phase(50, 50);
        check_replay();

        // Random phases within capacity
        for (int p = 0; p < 4; p++) begin
            gen_seq(int'($urandom_range(1, MAX)));
            drive_phase(0, 0);
            check_replay();
        end

        // More pulses than the store holds
        gen_seq(MAX + 1);
        drive_phase(0, 0);
        check_replay();

        // Lose during the gap: FIM next cycle, leave only on disable
        seq = '{4'b1000, 4'b0100};
        drive_phase(30, 30);
        wait_botoes(1'b1);
        wait_botoes(1'b0);
        perdeu = 1'b1;
        @(negedge clock);
        check("perdeu_estado", 32'(db_estado), 15);
        check("perdeu_fim", 32'(fim), 1);
        check("perdeu_botoes", 32'(botoes), 0);
        perdeu = 1'b0;
        @(negedge clock);
        check("fim_mantido", 32'(db_estado), 15);
        habilita = 1'b0;
        @(negedge clock);
        check("fim_para_ocioso", 32'(db_estado), 0);
        check("fim_baixo", 32'(fim), 0);

        // Re-enable clears overflow; disable mid-press discards the sequence
        habilita = 1'b1;
        exp_ovf  = 1'b0;
        @(negedge clock);
        check("reabilita_overflow", 32'(overflow), 0);
        seq = '{4'b0011, 4'b0101};
        drive_phase(20, 20);
        wait_botoes(1'b1);
        habilita = 1'b0;
        @(negedge clock);
        check("abort_botoes", 32'(botoes), 0);
        check("abort_estado", 32'(db_estado), 0);
        check("abort_contagem", 32'(db_contagem), 0);
        habilita = 1'b1;
        @(negedge clock);
        check("reabilita_contagem", 32'(db_contagem), 0);
        check("reabilita_estado", 32'(db_estado), 1);
        seq = '{4'b0010};
        drive_phase(10, 10);
        check_replay();

        // Asynchronous reset in the middle of a press
        seq = '{4'b0100, 4'b0001};
        drive_phase(15, 15);
        wait_botoes(1'b1);
        check("pre_reset_botoes", 32'(botoes), 32'(4'b0100));
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_botoes", 32'(botoes), 0);
        check("async_estado", 32'(db_estado), 0);
        check("async_contagem", 32'(db_contagem), 0);
        exp_ptr = 0;
        exp_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("pos_reset_estado", 32'(db_estado), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
